// File: rtl/multdiv_issue_if.sv
// ---------------------------------------------------------------------------
// multdiv_issue_if
// Link between the multdiv_issue initiator and the iterative mult/div unit.
//
// Signals:
//   md_start_mult  one-cycle start strobe for a multiply
//   md_start_div   one-cycle start strobe for a divide
//   md_operand_a   operand A, held stable for the whole operation
//   md_operand_b   operand B, held stable for the whole operation
//   md_result      result from the unit
//   md_exception   exception flag from the unit (e.g. divide by zero)
//   md_ready       result valid from the unit
//
// Modports:
//   master  the initiator (multdiv_issue)
//   slave   the mult/div unit
// ---------------------------------------------------------------------------
interface multdiv_issue_if #(
    parameter int DATA_W = 32
);
    logic              md_start_mult;
    logic              md_start_div;
    logic [DATA_W-1:0] md_operand_a;
    logic [DATA_W-1:0] md_operand_b;
    logic [DATA_W-1:0] md_result;
    logic              md_exception;
    logic              md_ready;

    modport master (
        output md_start_mult,
        output md_start_div,
        output md_operand_a,
        output md_operand_b,
        input  md_result,
        input  md_exception,
        input  md_ready
    );

    modport slave (
        input  md_start_mult,
        input  md_start_div,
        input  md_operand_a,
        input  md_operand_b,
        output md_result,
        output md_exception,
        output md_ready
    );
endinterface

// File: rtl/multdiv_issue.sv
// ---------------------------------------------------------------------------
// multdiv_issue
// Pipeline-side initiator for the iterative mult/div unit. Accepts an op from
// execute, latches and holds its operands, pulses the start strobe, stalls
// the pipeline while waiting for the unit's ready (with a timeout), then
// presents a one-cycle writeback of the captured result/exception.
//
// Parameters:
//   DATA_W   operand/result width
//   TIMEOUT  max WAIT cycles before forced completion with exception (< 64)
//
// Ports:
//   clock, reset_n                 clock (rising edge), async active-low reset
//   op_valid, op_is_div            op request from execute, 1 = divide
//   operand_a, operand_b, op_dest  op operands and destination register
//   flush                          squash the in-flight op
//   md                             multdiv_issue_if.master link to the unit
//   stall, busy                    pipeline freeze, FSM not in IDLE
//   wb_valid, wb_data, wb_dest,
//   wb_exception                   one-cycle writeback and its held payload
//
// Optional feature (macro MULTDIV_ISSUE_DIV_ZERO_BYPASS_EN):
//   When defined, a divide with operand_b == 0 skips the unit entirely and
//   completes in DONE on the next cycle with wb_data = 0, wb_exception = 1.
// ---------------------------------------------------------------------------
module multdiv_issue #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 40
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              op_valid,
    input  logic              op_is_div,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [4:0]        op_dest,
    input  logic              flush,
    multdiv_issue_if.master   md,
    output logic              stall,
    output logic              busy,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_dest,
    output logic              wb_exception
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic [4:0]        dest_q;
    logic              is_div_q;
    logic [5:0]        timeout_cnt;

    logic              accept;
    logic              bypass;
    logic              capture_ready;
    logic              capture_timeout;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and outputs. stall in IDLE is combinational so the accepted
    // op is held upstream in the very cycle it is taken. md_ready is not
    // looked at in ISSUE: it may still be high from the previous op.
    always_comb begin
        state_next       = state;
        accept           = 1'b0;
        bypass           = 1'b0;
        capture_ready    = 1'b0;
        capture_timeout  = 1'b0;
        stall            = 1'b0;
        busy             = 1'b0;
        wb_valid         = 1'b0;
        md.md_start_mult = 1'b0;
        md.md_start_div  = 1'b0;

        case (state)
            IDLE: begin
                if (op_valid && !flush) begin
                    accept = 1'b1;
                    stall  = 1'b1;
`ifdef MULTDIV_ISSUE_DIV_ZERO_BYPASS_EN
                    if (op_is_div && (operand_b == '0)) begin
                        bypass     = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = ISSUE;
                    end
`else
                    state_next = ISSUE;
`endif
                end
            end
            ISSUE: begin
                busy             = 1'b1;
                stall            = 1'b1;
                md.md_start_mult = !is_div_q;
                md.md_start_div  = is_div_q;
                state_next       = flush ? IDLE : WAIT;
            end
            WAIT: begin
                busy  = 1'b1;
                stall = 1'b1;
                if (flush) begin
                    state_next = IDLE;
                end else if (md.md_ready) begin
                    capture_ready = 1'b1;
                    state_next    = DONE;
                end else if (timeout_cnt == TIMEOUT_LAST) begin
                    capture_timeout = 1'b1;
                    state_next      = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                wb_valid   = !flush;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latches, timeout counter and writeback capture. The writeback
    // payload is only rewritten on a capture, so it holds after DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_a_q       <= '0;
            op_b_q       <= '0;
            dest_q       <= '0;
            is_div_q     <= 1'b0;
            timeout_cnt  <= '0;
            wb_data      <= '0;
            wb_dest      <= '0;
            wb_exception <= 1'b0;
        end else begin
            if (accept) begin
                op_a_q   <= operand_a;
                op_b_q   <= operand_b;
                dest_q   <= op_dest;
                is_div_q <= op_is_div;
            end

            if (state == ISSUE) begin
                timeout_cnt <= '0;
            end else if (state == WAIT) begin
                timeout_cnt <= timeout_cnt + 6'd1;
            end

            if (capture_ready) begin
                wb_data      <= md.md_result;
                wb_exception <= md.md_exception;
                wb_dest      <= dest_q;
            end else if (capture_timeout) begin
                wb_data      <= '0;
                wb_exception <= 1'b1;
                wb_dest      <= dest_q;
            end else if (bypass) begin
                wb_data      <= '0;
                wb_exception <= 1'b1;
                wb_dest      <= op_dest;
            end
        end
    end

    assign md.md_operand_a = op_a_q;
    assign md.md_operand_b = op_b_q;

endmodule
